adv_ddr_serializer: RTL and testbench

Parametrised successor of the ADV7511 DDR video output stage. Runs entirely in the fast output clock domain. It synchronises the pixel-rate video bus, locks a phase counter to the sampled pixel clock, and emits each pixel as `PIX_W/OUT_W` slices with selectable slice order and optional blanking. It also reports phase-lock status and phase errors. It sits between the video generator and the ADV7511 input pins.

---
 rtl/adv_ddr_serializer.sv | 132 +++++++++++++
 tb/tb_adv_ddr_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adv_ddr_serializer.sv
// ============================================================================
// adv_ddr_serializer: phase-locks to a sampled pixel clock and slices pixels
// onto a narrower DDR output bus.             Revision: 1.0
// ============================================================================
`default_nettype none

module adv_ddr_serializer #(
    parameter int PIX_W       = 24,
    parameter int OUT_W       = 12,
    parameter int RATIO       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk_ddr,
    input  logic             reset_n,
    input  logic             clk_pixel,
    input  logic             de_in,
    input  logic             vsync,
    input  logic             hsync,
    input  logic [PIX_W-1:0] data,
    input  logic             swap_order,
    input  logic             blank_zero,
    output logic             clk_pixel_out,
    output logic             de_out,
    output logic             vsync_out,
    output logic             hsync_out,
    output logic [OUT_W-1:0] data_out,
    output logic             locked,
    output logic             phase_err
);

    localparam int SLICES = PIX_W / OUT_W;
    localparam int L      = RATIO / SLICES;
    localparam int PH_W   = $clog2(RATIO);
    localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
    localparam int SYN_W  = PIX_W + 4;

    localparam logic [PH_W-1:0]  c_PH_LAST  = PH_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0][SYN_W-1:0] r_sync;
    logic                              r_prev_clk;
    logic [PH_W-1:0]                   r_phase;
    logic [CNT_W-1:0]                  r_cnt;
    logic [PIX_W-1:0]                  r_hold;
    logic                              r_hold_de;

    logic             w_s_clk, w_s_de, w_s_vsync, w_s_hsync;
    logic [PIX_W-1:0] w_s_data;
    logic             w_rise, w_good, w_bad;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_slot_hit;
    logic [OUT_W-1:0] w_slot_val;

    assign {w_s_clk, w_s_de, w_s_vsync, w_s_hsync, w_s_data} = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s_clk & ~r_prev_clk;
    assign w_good = w_rise && (r_phase == c_PH_LAST);
    assign w_bad  = (w_rise && (r_phase != c_PH_LAST)) || (!w_rise && (r_phase == c_PH_LAST));

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_bad)
            w_cnt_nxt = '0;
        else if (w_good && (r_cnt != c_CNT_FULL))
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    // Slot 0 coincides with capture, so it reads the synchroniser directly.
    always_comb begin
        w_slot_hit = 1'b0;
        w_slot_val = '0;
        for (int k = 0; k < SLICES; k++) begin
            if (r_phase == PH_W'(k * L)) begin
                w_slot_hit = 1'b1;
                if (blank_zero && !((k == 0) ? w_s_de : r_hold_de))
                    w_slot_val = '0;
                else if (k == 0)
                    w_slot_val = w_s_data[(swap_order ? (SLICES-1-k) : k) * OUT_W +: OUT_W];
                else
                    w_slot_val = r_hold[(swap_order ? (SLICES-1-k) : k) * OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk_ddr or negedge reset_n) begin
        if (!reset_n) begin
            r_sync        <= '0;
            r_prev_clk    <= 1'b0;
            r_phase       <= '0;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_hold_de     <= 1'b0;
            clk_pixel_out <= 1'b0;
            de_out        <= 1'b0;
            vsync_out     <= 1'b0;
            hsync_out     <= 1'b0;
            data_out      <= '0;
            locked        <= 1'b0;
            phase_err     <= 1'b0;
        end else begin
            r_sync[0] <= {clk_pixel, de_in, vsync, hsync, data};
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];

            r_prev_clk    <= w_s_clk;
            clk_pixel_out <= w_s_clk;

            if (w_rise || (r_phase == c_PH_LAST))
                r_phase <= '0;
            else
                r_phase <= r_phase + PH_W'(1);

            r_cnt     <= w_cnt_nxt;
            locked    <= (w_cnt_nxt == c_CNT_FULL);
            phase_err <= w_bad;

            if (r_phase == '0) begin
                r_hold    <= w_s_data;
                r_hold_de <= w_s_de;
                de_out    <= w_s_de & locked;
                hsync_out <= w_s_hsync;
                vsync_out <= w_s_vsync;
            end

            if (w_slot_hit)
                data_out <= w_slot_val;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adv_ddr_serializer.sv
// ============================================================================
// tb_adv_ddr_serializer: directed bench for two- and three-slice serializers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adv_ddr_serializer;

    logic clk_ddr = 1'b0;
    always #5 clk_ddr = ~clk_ddr;

    logic        reset_n, clk_pixel, de_in, vsync, hsync, swap_order, blank_zero;
    logic [23:0] data;
    logic        clk_pixel_out, de_out, vsync_out, hsync_out, locked, phase_err;
    logic [11:0] data_out;

    logic        clk_pixel3, de3, swap3, blank3;
    logic [23:0] data3;
    logic        clk_pixel_out3, de_out3, vsync_out3, hsync_out3, locked3, phase_err3;
    logic [7:0]  data_out3;

    adv_ddr_serializer dut (
        .clk_ddr(clk_ddr), .reset_n(reset_n), .clk_pixel(clk_pixel),
        .de_in(de_in), .vsync(vsync), .hsync(hsync), .data(data),
        .swap_order(swap_order), .blank_zero(blank_zero),
        .clk_pixel_out(clk_pixel_out), .de_out(de_out), .vsync_out(vsync_out),
        .hsync_out(hsync_out), .data_out(data_out), .locked(locked),
        .phase_err(phase_err)
    );

    adv_ddr_serializer #(.PIX_W(24), .OUT_W(8), .RATIO(6)) dut3 (
        .clk_ddr(clk_ddr), .reset_n(reset_n), .clk_pixel(clk_pixel3),
        .de_in(de3), .vsync(vsync), .hsync(hsync), .data(data3),
        .swap_order(swap3), .blank_zero(blank3),
        .clk_pixel_out(clk_pixel_out3), .de_out(de_out3), .vsync_out(vsync_out3),
        .hsync_out(hsync_out3), .data_out(data_out3), .locked(locked3),
        .phase_err(phase_err3)
    );

    int errors = 0;
    int checks = 0;
    int pcnt = 0, per = 4, pcnt3 = 0;
    int last_p = 0, last_p3 = 0;
    int errpulse = 0;
    bit stretch_req = 1'b0;

    wire [31:0] outs  = {14'd0, clk_pixel_out, de_out, vsync_out, hsync_out, data_out, locked, phase_err};
    wire [31:0] outs3 = {18'd0, clk_pixel_out3, de_out3, vsync_out3, hsync_out3, data_out3, locked3, phase_err3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of both pixel clocks, then return at the following negedge.
    task automatic tick();
        if (pcnt == 0) begin
            per         = stretch_req ? 5 : 4;
            stretch_req = 1'b0;
        end
        clk_pixel  = (pcnt < 2);
        clk_pixel3 = (pcnt3 < 3);
        last_p     = pcnt;
        last_p3    = pcnt3;
        @(posedge clk_ddr);
        @(negedge clk_ddr);
        if (phase_err) errpulse++;
        pcnt  = (pcnt + 1 >= per) ? 0 : pcnt + 1;
        pcnt3 = (pcnt3 + 1) % 6;
    endtask

    task automatic wait_p(input int t);
        int n = 0;
        do begin
            tick();
            n++;
        end while (last_p != t && n < 20);
        if (last_p != t) begin
            checks++;
            errors++;
            $error("FAIL wait_p: observed=%0d expected=%0d", last_p, t);
        end
    endtask

    task automatic wait_p3(input int t);
        int n = 0;
        do begin
            tick();
            n++;
        end while (last_p3 != t && n < 20);
        if (last_p3 != t) begin
            checks++;
            errors++;
            $error("FAIL wait_p3: observed=%0d expected=%0d", last_p3, t);
        end
    endtask

    initial begin
        reset_n = 1'b0; clk_pixel = 1'b0; clk_pixel3 = 1'b0;
        data = 24'hABC123; de_in = 1'b1; hsync = 1'b1; vsync = 1'b0;
        swap_order = 1'b0; blank_zero = 1'b0;
        data3 = 24'h332211; de3 = 1'b1; swap3 = 1'b0; blank3 = 1'b0;
        #1;
        chk("reset_outs", outs, 32'd0);
        chk("reset_outs3", outs3, 32'd0);

        repeat (6) tick();
        while (pcnt != 0) tick();
        reset_n = 1'b1;

        // Startup: first edge is early, lock after four good edges.
        tick(); tick();
        tick(); chk("startup_early_err", phase_err, 1'b1);
        tick(); chk("err_one_cycle", phase_err, 1'b0);
        chk("slot0_lo", data_out, 12'h123);
        chk("de_gated_unlocked", de_out, 1'b0);
        errpulse = 0;
        tick(); chk("slot0_hold", data_out, 12'h123);
        tick(); chk("slot1_hi", data_out, 12'hABC);
        repeat (9) tick();
        tick(); chk("de_still_gated", de_out, 1'b0);
        tick();
        tick(); chk("not_locked_yet", locked, 1'b0);
        tick(); chk("locked_rise", locked, 1'b1);
        chk("clk_out_high", clk_pixel_out, 1'b1);
        tick(); chk("de_out_locked", de_out, 1'b1);
        chk("hsync_out", hsync_out, 1'b1);
        chk("vsync_out", vsync_out, 1'b0);
        tick(); chk("clk_out_low", clk_pixel_out, 1'b0);
        repeat (20) tick();
        chk("no_err_when_locked", errpulse, 0);

        // Swapped slice order.
        swap_order = 1'b1;
        wait_p(3); wait_p(3); chk("swap_slot0", data_out, 12'hABC);
        wait_p(1); chk("swap_slot1", data_out, 12'h123);
        swap_order = 1'b0;

        // Blanking with DE low.
        wait_p(3);
        blank_zero = 1'b1; de_in = 1'b0; data = 24'hFFFFFF;
        wait_p(3); chk("blank_slot0", data_out, 12'h000);
        chk("blank_de_out", de_out, 1'b0);
        wait_p(1); chk("blank_slot1", data_out, 12'h000);
        blank_zero = 1'b0;
        wait_p(3); chk("noblank_slot0", data_out, 12'hFFF);
        wait_p(1); chk("noblank_slot1", data_out, 12'hFFF);
        wait_p(3);
        de_in = 1'b1; data = 24'hABC123;
        wait_p(3); chk("restore_slot0", data_out, 12'h123);
        chk("restore_de", de_out, 1'b1);

        // One stretched pixel period: missing edge then early edge.
        wait_p(3);
        errpulse = 0;
        stretch_req = 1'b1;
        repeat (6) tick();
        chk("pre_stretch_err", phase_err, 1'b0);
        chk("pre_stretch_lock", locked, 1'b1);
        tick(); chk("missing_edge_err", phase_err, 1'b1);
        chk("lock_lost", locked, 1'b0);
        tick(); chk("early_edge_err", phase_err, 1'b1);
        tick(); chk("err_cleared", phase_err, 1'b0);
        chk("de_gated_relock", de_out, 1'b0);
        repeat (13) tick();
        tick(); chk("relock_pending", locked, 1'b0);
        tick(); chk("relocked", locked, 1'b1);
        chk("stretch_pulses", errpulse, 2);

        // Three-slice instance.
        wait_p3(3); chk("s3_slot0", data_out3, 8'h11);
        chk("s3_locked", locked3, 1'b1);
        tick(); tick(); chk("s3_slot1", data_out3, 8'h22);
        tick(); tick(); chk("s3_slot2", data_out3, 8'h33);
        swap3 = 1'b1;
        wait_p3(3); wait_p3(3); chk("s3_swap_slot0", data_out3, 8'h33);
        tick(); tick(); chk("s3_swap_slot1", data_out3, 8'h22);
        tick(); tick(); chk("s3_swap_slot2", data_out3, 8'h11);

        // Asynchronous reset mid-pixel.
        wait_p(1);
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_outs", outs, 32'd0);
        chk("midrun_reset_outs3", outs3, 32'd0);
        repeat (3) tick();
        chk("held_reset_outs", outs, 32'd0);
        reset_n = 1'b1;
        repeat (6) tick();
        chk("post_reset_de", de_out, 1'b0);
        chk("post_reset_lock", locked, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
